// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter, its three requesters
// (fetch, load/store, debug) and the single memory port.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch, load/store and debug,
// with fixed priority, a debug starvation guard and a memory wait timeout.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate among pending requests
// ISSUE | mem_en strobe for the granted port; wait timer loaded
// WAIT  | waiting on mem_ready; abort when the wait timer expires
// RESP  | ack to the owner; arbitrate the other ports for a back-to-back grant
module mem_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.slave        bus,
    output logic                     busy,
    output logic [1:0]               owner,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;
    localparam logic [1:0] OWN_DBG  = 2'b11;

    localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]      WAIT_LOAD  = 8'(TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        owner_q;
    logic [1:0]        grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wait_cnt_q;
    logic [SW-1:0]     starve_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              terr_q;

    logic              arb_en;
    logic              cand_if;
    logic              cand_dm;
    logic              cand_dbg;
    logic              wait_hit;
    logic              wait_abort;
    logic              rd_load;
    logic [DATA_W-1:0] rd_val;

    // The port being acknowledged in RESP still has req high; keep it out
    // of the race so it cannot be granted twice for one request.
    always_comb begin
        arb_en   = (state_q == ST_IDLE) || (state_q == ST_RESP);
        cand_if  = arb_en && bus.if_req  && !((state_q == ST_RESP) && (owner_q == OWN_IF));
        cand_dm  = arb_en && bus.dm_req  && !((state_q == ST_RESP) && (owner_q == OWN_DM));
        cand_dbg = arb_en && bus.dbg_req && !((state_q == ST_RESP) && (owner_q == OWN_DBG));

        grant = OWN_NONE;
        if (cand_dbg && (starve_q == STARVE_MAX)) begin
            grant = OWN_DBG;
        end else if (cand_dm) begin
            grant = OWN_DM;
        end else if (cand_if) begin
            grant = OWN_IF;
        end else if (cand_dbg) begin
            grant = OWN_DBG;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_hit   = 1'b0;
        wait_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != OWN_NONE) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    wait_hit = 1'b1;
                    state_d  = ST_RESP;
                end else if (wait_cnt_q == 8'd0) begin
                    wait_abort = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = (grant != OWN_NONE) ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant only fires in IDLE or RESP, so the latched request stays
    // stable on the memory bus from ISSUE through WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant != OWN_NONE) begin
            owner_q <= grant;
            case (grant)
                OWN_DM: begin
                    we_q    <= bus.dm_we;
                    addr_q  <= bus.dm_addr;
                    wdata_q <= bus.dm_wdata;
                end
                OWN_DBG: begin
                    we_q    <= bus.dbg_we;
                    addr_q  <= bus.dbg_addr;
                    wdata_q <= bus.dbg_wdata;
                end
                default: begin
                    we_q    <= 1'b0;
                    addr_q  <= bus.if_addr;
                    wdata_q <= '0;
                end
            endcase
        end else if (state_q == ST_RESP) begin
            owner_q <= OWN_NONE;
        end
    end

    // Down-counter: loaded in ISSUE, so WAIT spans TIMEOUT+1 cycles before
    // the terminal-count abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && !bus.mem_ready && (wait_cnt_q != 8'd0)) begin
            wait_cnt_q <= wait_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (!bus.dbg_req || (grant == OWN_DBG)) begin
            starve_q <= '0;
        end else if ((owner_q != OWN_DBG) && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Stores never touch the read-data registers, even on abort.
    assign rd_load = (wait_hit || wait_abort) && !we_q;
    assign rd_val  = wait_hit ? bus.mem_rdata : '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else if (rd_load) begin
            case (owner_q)
                OWN_IF:  if_rdata_q  <= rd_val;
                OWN_DM:  dm_rdata_q  <= rd_val;
                OWN_DBG: dbg_rdata_q <= rd_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            terr_q <= 1'b0;
        end else if (wait_abort) begin
            terr_q <= 1'b1;
        end
    end

    assign bus.mem_en    = (state_q == ST_ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign bus.dm_ack    = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign bus.dbg_ack   = (state_q == ST_RESP) && (owner_q == OWN_DBG);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-built
// back-to-back, starvation, reset-abort and stray-ready sequences.
module tb_mem_port_arbiter;

    localparam int TIMEOUT      = 15;
    localparam int STARVE_LIMIT = 8;
    localparam logic [1:0] P_IF  = 2'd1;
    localparam logic [1:0] P_DM  = 2'd2;
    localparam logic [1:0] P_DBG = 2'd3;

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;        // WAIT cycle index of mem_ready, -1 = never
        logic [15:0] mrdata;
        logic [15:0] exp_rdata;
        int          exp_lat;    // request cycle to ack cycle
        logic        exp_terr;
    } vec_t;

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [1:0]  port;
        logic [15:0] rdata;
    } ack_exp_t;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_err;

    mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_port_arbiter #(
        .DATA_W(16), .ADDR_W(16), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acks = 0;
    int          last_ack_cyc = 0;
    int          last_en_cyc = 0;
    int          last_dbg_en_cyc = -1000;
    int          resp_lat = 0;
    int          resp_cnt = 0;
    logic [15:0] resp_val = 16'h0;
    mem_exp_t    exp_mem[$];
    ack_exp_t    exp_ack[$];
    vec_t        vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] port_rdata(input logic [1:0] p);
        case (p)
            P_IF:    return bus.if_rdata;
            P_DM:    return bus.dm_rdata;
            default: return bus.dbg_rdata;
        endcase
    endfunction

    // One clock: memory responder, then scoreboard checks on mem_en / ack.
    task automatic tick();
        mem_exp_t   m;
        ack_exp_t   a;
        logic [2:0] av;
        logic [1:0] ap;
        @(posedge clk);
        #1;
        cyc++;
        bus.mem_ready = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = resp_val;
            end
        end
        if (bus.mem_en === 1'b1) begin
            if (resp_lat >= 0) resp_cnt = resp_lat + 1;
            last_en_cyc = cyc;
            if (owner == P_DBG) last_dbg_en_cyc = cyc;
            if (exp_mem.size() == 0) begin
                chk("unexpected_mem_en", 32'(bus.mem_en), 32'd0);
            end else begin
                m = exp_mem.pop_front();
                chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                if (m.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
                chk("owner_issue", 32'(owner), 32'(m.port));
                chk("busy_issue", 32'(busy), 32'd1);
            end
        end
        av = {bus.dbg_ack, bus.dm_ack, bus.if_ack};
        if (av !== 3'b000) begin
            n_acks++;
            last_ack_cyc = cyc;
            chk("ack_onehot", 32'($countones(av)), 32'd1);
            ap = bus.if_ack ? P_IF : (bus.dm_ack ? P_DM : P_DBG);
            if (exp_ack.size() == 0) begin
                chk("spurious_ack", 32'(av), 32'd0);
            end else begin
                a = exp_ack.pop_front();
                chk("ack_port", 32'(ap), 32'(a.port));
                chk("ack_rdata", 32'(port_rdata(a.port)), 32'(a.rdata));
            end
        end
    endtask

    task automatic wait_acks(input string name, input int target);
        for (int i = 0; i < 80 && n_acks < target; i++) tick();
        if (n_acks < target) chk(name, 32'(n_acks), 32'(target));
    endtask

    task automatic drive_req(input logic [1:0] p, input logic r, input logic we,
                             input logic [15:0] addr, input logic [15:0] wd);
        case (p)
            P_IF: begin
                bus.if_req = r; bus.if_addr = addr;
            end
            P_DM: begin
                bus.dm_req = r; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wd;
            end
            default: begin
                bus.dbg_req = r; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
            end
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        int acks0;
        exp_mem.push_back('{v.port, (v.port == P_IF) ? 1'b0 : v.we, v.addr, v.wdata});
        exp_ack.push_back('{v.port, v.exp_rdata});
        resp_lat = v.lat;
        resp_val = v.mrdata;
        drive_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        t0    = cyc;
        acks0 = n_acks;
        wait_acks("ack_timeout", acks0 + 1);
        chk("latency", 32'(last_ack_cyc - t0), 32'(v.exp_lat));
        chk("timeout_err", 32'(timeout_err), 32'(v.exp_terr));
        tick();
        drive_req(v.port, 1'b0, v.we, v.addr, v.wdata);
        chk("rdata_hold", 32'(port_rdata(v.port)), 32'(v.exp_rdata));
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int acks0;
        int t_dbg;
        int dm_ack_c;

        //          port   we    addr      wdata     lat mrdata    exp_rd    lat terr
        vecs[0]  = '{P_IF,  1'b0, 16'h0040, 16'h0000,  0, 16'h1234, 16'h1234,  3, 1'b0};
        vecs[1]  = '{P_DM,  1'b0, 16'h0200, 16'h0000,  2, 16'hA5A5, 16'hA5A5,  5, 1'b0};
        vecs[2]  = '{P_DBG, 1'b1, 16'h0300, 16'h5555,  1, 16'h0F00, 16'h0000,  4, 1'b0};
        vecs[3]  = '{P_DBG, 1'b0, 16'h0304, 16'h0000,  0, 16'h7E7E, 16'h7E7E,  3, 1'b0};
        vecs[4]  = '{P_DM,  1'b1, 16'h0100, 16'hBEEF,  3, 16'h0C0C, 16'hA5A5,  6, 1'b0};
        vecs[5]  = '{P_IF,  1'b0, 16'h0042, 16'h0000, 15, 16'h0F0F, 16'h0F0F, 18, 1'b0};
        vecs[6]  = '{P_DM,  1'b0, 16'h0204, 16'h0000, -1, 16'h0000, 16'hFFFF, 18, 1'b1};
        vecs[7]  = '{P_IF,  1'b0, 16'h0044, 16'h0000,  1, 16'h2222, 16'h2222,  4, 1'b1};
        vecs[8]  = '{P_DBG, 1'b0, 16'h0308, 16'h0000, 16, 16'h1111, 16'hFFFF, 18, 1'b1};
        vecs[9]  = '{P_IF,  1'b1, 16'h0046, 16'hDEAD,  0, 16'h3333, 16'h3333,  3, 1'b1};
        vecs[10] = '{P_DBG, 1'b1, 16'h030C, 16'h0A0A, -1, 16'h0000, 16'hFFFF, 18, 1'b1};

        reset = 1'b0;
        bus.if_req = 1'b0;  bus.if_addr = 16'h0;
        bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = 16'h0;  bus.dm_wdata = 16'h0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0; bus.dbg_wdata = 16'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        chk("rst_rdata", 32'(bus.if_rdata | bus.dm_rdata | bus.dbg_rdata), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Simultaneous dm store and fetch: dm first, fetch issues right after dm RESP.
        resp_lat = 0;
        resp_val = 16'h4444;
        exp_mem.push_back('{P_DM, 1'b1, 16'h0100, 16'hBEEF});
        exp_mem.push_back('{P_IF, 1'b0, 16'h0050, 16'h0000});
        exp_ack.push_back('{P_DM, 16'hFFFF});
        exp_ack.push_back('{P_IF, 16'h4444});
        acks0 = n_acks;
        drive_req(P_DM, 1'b1, 1'b1, 16'h0100, 16'hBEEF);
        drive_req(P_IF, 1'b1, 1'b0, 16'h0050, 16'h0000);
        wait_acks("b2b_dm_ack_timeout", acks0 + 1);
        dm_ack_c = last_ack_cyc;
        tick();
        bus.dm_req = 1'b0;
        wait_acks("b2b_if_ack_timeout", acks0 + 2);
        chk("b2b_gap", 32'(last_en_cyc - dm_ack_c), 32'd1);
        chk("b2b_dm_rdata", 32'(bus.dm_rdata), 32'hFFFF);
        tick();
        bus.if_req = 1'b0;

        // Debug request against a continuous dm/if alternation.
        resp_lat = 0;
        resp_val = 16'h6666;
        exp_mem.push_back('{P_DM,  1'b0, 16'h0500, 16'h0000});
        exp_mem.push_back('{P_IF,  1'b0, 16'h0050, 16'h0000});
        exp_mem.push_back('{P_DM,  1'b0, 16'h0500, 16'h0000});
        exp_mem.push_back('{P_DBG, 1'b0, 16'h0400, 16'h0000});
        exp_ack.push_back('{P_DM,  16'h6666});
        exp_ack.push_back('{P_IF,  16'h6666});
        exp_ack.push_back('{P_DM,  16'h6666});
        exp_ack.push_back('{P_DBG, 16'h6666});
        acks0 = n_acks;
        drive_req(P_DM, 1'b1, 1'b0, 16'h0500, 16'h0000);
        drive_req(P_IF, 1'b1, 1'b0, 16'h0050, 16'h0000);
        tick();
        drive_req(P_DBG, 1'b1, 1'b0, 16'h0400, 16'h0000);
        t_dbg = cyc;
        wait_acks("starve_ack_timeout", acks0 + 4);
        bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.dbg_req = 1'b0;
        chk("starve_bound", 32'((last_dbg_en_cyc - t_dbg >= 1) &&
                                (last_dbg_en_cyc - t_dbg <= STARVE_LIMIT + 1)), 32'd1);
        tick();
        chk("starve_idle", 32'({busy, owner}), 32'd0);

        // Reset in the middle of a fetch's WAIT; its late mem_ready must be ignored.
        resp_lat = 5;
        resp_val = 16'h7777;
        exp_mem.push_back('{P_IF, 1'b0, 16'h0060, 16'h0000});
        drive_req(P_IF, 1'b1, 1'b0, 16'h0060, 16'h0000);
        repeat (3) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        bus.if_req = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_terr_cleared", 32'(timeout_err), 32'd0);
        chk("abort_if_rdata", 32'(bus.if_rdata), 32'd0);
        chk("abort_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        reset = 1'b1;
        acks0 = n_acks;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("late_ready_busy", 32'(busy), 32'd0);
        end
        chk("no_ack_after_reset", 32'(n_acks - acks0), 32'd0);
        chk("late_ready_rdata", 32'(bus.if_rdata), 32'd0);

        // Stray mem_ready while idle with no requests.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        acks0 = n_acks;
        repeat (3) tick();
        chk("stray_state", 32'({busy, owner}), 32'd0);
        chk("stray_ack", 32'(n_acks - acks0), 32'd0);
        chk("stray_rdata", 32'(bus.if_rdata | bus.dm_rdata | bus.dbg_rdata), 32'd0);

        run_vec('{P_IF, 1'b0, 16'h0070, 16'h0000, 0, 16'hABCD, 16'hABCD, 3, 1'b0});
        run_vec('{P_DM, 1'b0, 16'h0210, 16'h0000, 4, 16'h5A5A, 16'h5A5A, 7, 1'b0});

        chk("scoreboard_empty", 32'(exp_mem.size() + exp_ack.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single memory port of the multicycle CPU among three requesters: instruction fetch, data load/store and the debug/loader port. The control FSM's fetch and load/store states raise requests here and stall until acknowledged. Each transaction is sequenced through a four-state FSM with a variable-latency memory handshake, a starvation guard for the debug port and a wait-timeout.

## Interface
- DATA_W, 16, data width
- ADDR_W, 16, address width
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255)
- STARVE_LIMIT, 8, cycles a pending debug request may be bypassed by CPU requests

- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- if_req  input  1  instruction-fetch request (read only)
- if_addr  input  ADDR_W  fetch address
- if_ack  output  1  one-cycle completion pulse
- if_rdata  output  DATA_W  fetched word; valid on if_ack, held until next if_ack
- dm_req, dm_we  input  1 each  data request; 1 = store
- dm_addr  input  ADDR_W;  dm_wdata  input  DATA_W
- dm_ack  output  1;  dm_rdata  output  DATA_W  (same rules as if_*)
- dbg_req, dbg_we  input  1 each;  dbg_addr  input  ADDR_W;  dbg_wdata  input  DATA_W
- dbg_ack  output  1;  dbg_rdata  output  DATA_W
- mem_en  output  1  one-cycle strobe starting a memory access
- mem_we  output  1;  mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W  (held from ISSUE through WAIT)
- mem_rdata  input  DATA_W;  mem_ready  input  1  access complete
- busy  output  1  high in any state other than IDLE
- owner  output  2  00 none, 01 if, 10 dm, 11 dbg
- timeout_err  output  1  sticky; set on any timeout abort

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration (in IDLE, and in RESP): winner chosen from ports with req high. dbg wins if its starve counter equals STARVE_LIMIT; otherwise dm > if > dbg.
- In RESP the port being acknowledged is excluded from arbitration (its req is still high that cycle).
- Grant: latch owner, we, addr, wdata; go to ISSUE. if port always latched as we=0.
- ISSUE: mem_en=1 exactly one cycle; go to WAIT; clear wait counter.
- WAIT: sample mem_ready. High: capture mem_rdata into owner's rdata register (reads only; stores leave rdata unchanged), go to RESP. Low: increment wait counter; at TIMEOUT, abort: owner's rdata = all ones (reads), timeout_err=1, go to RESP.
- RESP: owner's ack=1 for one cycle; if another port wins arbitration go to ISSUE, else IDLE with owner=00.
- Starve counter: increments each cycle dbg_req=1 and dbg not owner; saturates at STARVE_LIMIT; clears when dbg granted or dbg_req=0.
- Requesters hold req and payload stable until ack. A req dropped before grant is ignored. A req dropped after grant: transaction completes and ack still pulses.
- mem_ready outside WAIT is ignored.
- Reset (reset=0 at clock edge): state IDLE, owner 00, all acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, all rdata 0, busy 0, timeout_err 0, counters 0. In-flight transaction discarded with no ack; timeout_err clears only on reset.

## Timing
- req high in cycle 0 (IDLE) -> ISSUE/mem_en in cycle 1 -> WAIT cycle 2 -> mem_ready in cycle 2 gives ack in cycle 3. Minimum latency 3 cycles; each extra memory wait cycle adds one.
- Back-to-back: second requester pending during RESP gets mem_en in the cycle after RESP (no IDLE bubble).
- Timeout: with mem_ready never high, ack occurs TIMEOUT+1 cycles after ISSUE... precisely: WAIT lasts TIMEOUT+1 cycles, RESP follows.
- busy and owner are registered, valid from cycle 1 of a grant through RESP.

## Test plan
- Reset then if_req=1, if_addr=0x0040, mem_ready high first WAIT cycle with mem_rdata=0x1234 -> mem_en cycle 1, if_ack cycle 3, if_rdata=0x1234 held afterwards.
- if_req and dm_req (we=1, addr 0x0100, wdata 0xBEEF) together -> dm served first (mem_we=1, mem_wdata=0xBEEF), if gets mem_en the cycle after dm_ack, dm_rdata unchanged.
- dbg_req held while if_req/dm_req continuously alternate -> dbg granted no later than STARVE_LIMIT=8 cycles after assertion; owner=11.
- mem_ready held low, dm read -> dm_ack after TIMEOUT+1 WAIT cycles, dm_rdata=0xFFFF, timeout_err=1 and stays 1 until reset.
- reset=0 during WAIT of a fetch -> next cycle IDLE, busy=0, no if_ack ever issued for that fetch; late mem_ready ignored.
- mem_ready pulsed while IDLE with no requests -> no ack, no state change.
